// File: rtl/nios_system_otg_hpi_pkg.sv
// Shared definitions for the Avalon-to-HPI bus cycle sequencer:
// FSM state encoding and CY7C67200 HPI register select codes.
package nios_system_otg_hpi_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        SETUP   = S_SETUP,
        STROBE  = S_STROBE,
        HOLD    = S_HOLD,
        RECOVER = S_RECOVER
    } hpi_state_e;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/nios_system_otg_hpi_timer.sv
// Loadable down-counter that times each HPI phase; a phase ends when it reads zero.
module nios_system_otg_hpi_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/nios_system_otg_hpi_ctrl.sv
// Avalon-MM slave that turns each accepted transfer into one timed 16-bit HPI
// bus cycle (setup, strobe, hold, recovery) on the CY7C67200 OTG pins.
module nios_system_otg_hpi_ctrl
    import nios_system_otg_hpi_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LOAD    = (RECOVER_CYC > 0) ? CNT_W'(RECOVER_CYC - 1) : '0;

    hpi_state_e       state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             is_write_q, is_write_d;
    logic             live_q, live_d;
    logic [15:0]      readdata_q, readdata_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic             oe_q, oe_d;
    logic [15:0]      data_out_q, data_out_d;
    logic             active_d;
    logic             req;
    logic             ack;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_value;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    nios_system_otg_hpi_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value),
        .zero       (tmr_zero)
    );

    assign req = chipselect & (read | write);
    // A master that dropped its request mid-cycle must not see the ack of that old cycle.
    assign ack = (state_q == HOLD) & tmr_zero & live_q;
    assign waitrequest = req & ~ack;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        is_write_d     = is_write_q;
        live_d         = live_q & req;
        readdata_d     = readdata_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d        = SETUP;
                    addr_d         = address;
                    wdata_d        = writedata;
                    is_write_d     = write;
                    live_d         = 1'b1;
                    tmr_load       = 1'b1;
                    tmr_load_value = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d        = STROBE;
                    tmr_load       = 1'b1;
                    tmr_load_value = STROBE_LOAD;
                end
            end
            STROBE: begin
                if (tmr_zero) begin
                    state_d        = HOLD;
                    tmr_load       = 1'b1;
                    tmr_load_value = HOLD_LOAD;
                    if (!is_write_q) begin
                        readdata_d = otg_data_in;
                    end
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    if (RECOVER_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d        = RECOVER;
                        tmr_load       = 1'b1;
                        tmr_load_value = REC_LOAD;
                    end
                end
            end
            RECOVER: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins follow the next state so they change cleanly on the same edge as the FSM.
        active_d   = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        cs_n_d     = ~active_d;
        rd_n_d     = ~((state_d == STROBE) && !is_write_d);
        wr_n_d     = ~((state_d == STROBE) && is_write_d);
        oe_d       = active_d & is_write_d;
        data_out_d = oe_d ? wdata_d : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            live_q     <= 1'b0;
            readdata_q <= '0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            live_q     <= live_d;
            readdata_q <= readdata_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            oe_q       <= oe_d;
            data_out_q <= data_out_d;
        end
    end

    assign readdata     = readdata_q;
    assign otg_cs_n     = cs_n_q;
    assign otg_rd_n     = rd_n_q;
    assign otg_wr_n     = wr_n_q;
    assign otg_addr     = addr_q;
    assign otg_data_out = data_out_q;
    assign otg_data_oe  = oe_q;

endmodule

// File: tb/tb_nios_system_otg_hpi_ctrl.sv
// Directed bench for the HPI sequencer: default-timing instance plus a RECOVER_CYC=0 build.
module tb_nios_system_otg_hpi_ctrl;
    import nios_system_otg_hpi_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic [1:0]  otg_addr;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;

    logic [1:0]  b_address;
    logic        b_chipselect;
    logic        b_read;
    logic        b_write;
    logic [15:0] b_writedata;
    logic [15:0] b_readdata;
    logic        b_waitrequest;
    logic        b_otg_cs_n;
    logic        b_otg_rd_n;
    logic        b_otg_wr_n;
    logic [1:0]  b_otg_addr;
    logic [15:0] b_otg_data_out;
    logic        b_otg_data_oe;
    logic [15:0] b_otg_data_in;

    int n_vec = 0;
    int n_bad = 0;

    nios_system_otg_hpi_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .otg_cs_n     (otg_cs_n),
        .otg_rd_n     (otg_rd_n),
        .otg_wr_n     (otg_wr_n),
        .otg_addr     (otg_addr),
        .otg_data_out (otg_data_out),
        .otg_data_oe  (otg_data_oe),
        .otg_data_in  (otg_data_in)
    );

    nios_system_otg_hpi_ctrl #(
        .RECOVER_CYC (0)
    ) dut_norec (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (b_address),
        .chipselect   (b_chipselect),
        .read         (b_read),
        .write        (b_write),
        .writedata    (b_writedata),
        .readdata     (b_readdata),
        .waitrequest  (b_waitrequest),
        .otg_cs_n     (b_otg_cs_n),
        .otg_rd_n     (b_otg_rd_n),
        .otg_wr_n     (b_otg_wr_n),
        .otg_addr     (b_otg_addr),
        .otg_data_out (b_otg_data_out),
        .otg_data_oe  (b_otg_data_oe),
        .otg_data_in  (b_otg_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered at the start of cycle 0 with the controller idle; returns at the start of cycle 7.
    task automatic do_xfer(input logic wr, input logic rd, input logic [1:0] a,
                           input logic [15:0] wd, input logic [15:0] pin);
        bit in_sel, in_stb;
        chipselect = 1'b1;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        for (int c = 0; c <= 6; c++) begin
            otg_data_in = (c >= 2 && c <= 5) ? pin : 16'hDEAD;
            if (c == 2) begin
                address   = ~a;
                writedata = ~wd;
            end
            in_sel = (c >= 1 && c <= 6);
            in_stb = (c >= 2 && c <= 5);
            @(negedge clk);
            check_val($sformatf("cs_n c%0d", c), 32'(otg_cs_n), 32'(!in_sel));
            check_val($sformatf("wr_n c%0d", c), 32'(otg_wr_n), 32'(!(wr && in_stb)));
            check_val($sformatf("rd_n c%0d", c), 32'(otg_rd_n), 32'(!(!wr && in_stb)));
            check_val($sformatf("oe c%0d", c), 32'(otg_data_oe), 32'(wr && in_sel));
            check_val($sformatf("waitreq c%0d", c), 32'(waitrequest), 32'(c != 6));
            if (wr && in_sel) check_val($sformatf("data_out c%0d", c), 32'(otg_data_out), 32'(wd));
            if (in_sel) check_val($sformatf("addr c%0d", c), 32'(otg_addr), 32'(a));
            if (c == 6 && !wr) check_val("readdata ack", 32'(readdata), 32'(pin));
            @(posedge clk);
            #1;
        end
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        $display("xfer %s addr=%0d wdata=%h readdata=%h", wr ? "write" : "read", a, wd, readdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; otg_data_in = '0;
        b_address = '0; b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
        b_writedata = '0; b_otg_data_in = 16'h7E57;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst cs_n", 32'(otg_cs_n), 32'd1);
        check_val("rst rd_n", 32'(otg_rd_n), 32'd1);
        check_val("rst wr_n", 32'(otg_wr_n), 32'd1);
        check_val("rst oe", 32'(otg_data_oe), 32'd0);
        check_val("rst readdata", 32'(readdata), 32'd0);
        check_val("rst waitreq", 32'(waitrequest), 32'd0);
        check_val("rst addr", 32'(otg_addr), 32'd0);
        check_val("rst data_out", 32'(otg_data_out), 32'd0);
        $display("reset applied");
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Write, then a read held from the ack onward: second SETUP lands in cycle 10.
        do_xfer(1'b1, 1'b0, HPI_ADDR, 16'h1234, 16'h0000);
        chipselect = 1'b1; read = 1'b1; address = HPI_DATA;
        for (int c = 7; c <= 8; c++) begin
            @(negedge clk);
            check_val($sformatf("b2b cs_n c%0d", c), 32'(otg_cs_n), 32'd1);
            check_val($sformatf("b2b oe c%0d", c), 32'(otg_data_oe), 32'd0);
            check_val($sformatf("b2b waitreq c%0d", c), 32'(waitrequest), 32'd1);
            @(posedge clk);
            #1;
        end
        do_xfer(1'b0, 1'b1, HPI_DATA, 16'h0000, 16'hBEEF);
        idle(3);

        do_xfer(1'b1, 1'b1, HPI_MAILBOX, 16'hA5C3, 16'h0000);
        idle(3);

        // Reset pulse in the middle of a write strobe.
        chipselect = 1'b1; write = 1'b1; address = HPI_STATUS; writedata = 16'h5A5A;
        idle(3);
        @(negedge clk);
        check_val("pre-rst wr_n", 32'(otg_wr_n), 32'd0);
        check_val("pre-rst cs_n", 32'(otg_cs_n), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check_val("async cs_n", 32'(otg_cs_n), 32'd1);
        check_val("async wr_n", 32'(otg_wr_n), 32'd1);
        check_val("async oe", 32'(otg_data_oe), 32'd0);
        check_val("async data_out", 32'(otg_data_out), 32'd0);
        chipselect = 1'b0; write = 1'b0;
        #1;
        check_val("async waitreq", 32'(waitrequest), 32'd0);
        reset_n = 1'b1;
        $display("reset pulsed mid-strobe");
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("post-rst cs_n", 32'(otg_cs_n), 32'd1);
        @(posedge clk);
        #1;
        do_xfer(1'b0, 1'b1, HPI_STATUS, 16'h0000, 16'h0F0F);
        idle(3);

        // RECOVER_CYC=0 build: write then read held; second SETUP in cycle 8.
        b_chipselect = 1'b1; b_write = 1'b1; b_address = HPI_DATA; b_writedata = 16'hC0DE;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            check_val($sformatf("norec cs_n c%0d", c), 32'(b_otg_cs_n),
                      32'(!((c >= 1 && c <= 6) || (c >= 8 && c <= 13))));
            check_val($sformatf("norec waitreq c%0d", c), 32'(b_waitrequest),
                      32'(!(c == 6 || c == 13)));
            check_val($sformatf("norec rd_n c%0d", c), 32'(b_otg_rd_n), 32'(!(c >= 9 && c <= 12)));
            if (c == 13) check_val("norec readdata", 32'(b_readdata), 32'h7E57);
            @(posedge clk);
            #1;
            if (c == 6) begin
                b_write = 1'b0;
                b_read  = 1'b1;
            end
        end
        b_chipselect = 1'b0; b_read = 1'b0;
        $display("norec write+read readdata=%h", b_readdata);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
